// File: rtl/icache_controller_if.sv
// icache_controller_if
//   Bundles the CPU fetch port and the instruction-memory block port of the
//   instruction cache.
//   CPU side    : read, pc (in to cache); instruction, busywait (out of cache)
//   Memory side : mem_read, mem_address (out of cache);
//                 mem_readdata, mem_busywait (in to cache)
//   slave  - the cache controller's view
//   master - the environment's view (CPU fetch stage plus instruction memory)
interface icache_controller_if;
  logic         read;
  logic [31:0]  pc;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  read, pc, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output read, pc, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/icache_controller.sv
// icache_controller
//   Direct-mapped instruction cache, 2**INDEX_BITS lines of 16 bytes each.
//   Hits return the addressed 32-bit word combinationally; a miss stalls the
//   CPU on busywait while one 128-bit block is read from instruction memory
//   and written into the line.
//   Ports:
//     clk   - clock, all state updates on the rising edge
//     reset - synchronous, active-high; clears FSM and all lines
//     bus   - icache_controller_if.slave (CPU fetch + memory block port)
//
//   state      | meaning
//   S_IDLE     | serving hits; a miss latches the block address
//   S_MEM_READ | mem_read high, waiting for memory to assert then drop busy
//   S_UPDATE   | writing the fill buffer, tag and valid into the line
module icache_controller #(
  parameter int INDEX_BITS = 3
) (
  input logic               clk,
  input logic               reset,
  icache_controller_if.slave bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_array  [LINES];
  logic [127:0]          data_array [LINES];
  logic [27:0]           miss_addr;
  logic [127:0]          fill_buf;
  logic                  busy_seen;
  logic                  mem_read_q;

  logic [1:0]            word;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;

  assign word     = bus.pc[3:2];
  assign idx      = bus.pc[3+INDEX_BITS:4];
  assign tag      = bus.pc[31:4+INDEX_BITS];
  assign hit      = bus.read & valid[idx] & (tag_array[idx] == tag);

  assign fill_idx = miss_addr[INDEX_BITS-1:0];
  assign fill_tag = miss_addr[27:INDEX_BITS];

  assign bus.instruction = data_array[idx][{word, 5'b00000} +: 32];
  assign bus.busywait    = bus.read & ((state != S_IDLE) | ~hit);
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = miss_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_read_q <= 1'b0;
      busy_seen  <= 1'b0;
      miss_addr  <= '0;
      fill_buf   <= '0;
      valid      <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_array[i]  <= '0;
        data_array[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.read && !hit) begin
            miss_addr  <= bus.pc[31:4];
            mem_read_q <= 1'b1;
            state      <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          // A low busy before memory has ever asserted it is not a response.
          if (bus.mem_busywait) begin
            busy_seen <= 1'b1;
          end else if (busy_seen) begin
            fill_buf   <= bus.mem_readdata;
            mem_read_q <= 1'b0;
            state      <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          data_array[fill_idx] <= fill_buf;
          tag_array[fill_idx]  <= fill_tag;
          valid[fill_idx]      <= 1'b1;
          busy_seen            <= 1'b0;
          state                <= S_IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
module tb_icache_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_controller_if bus();

  icache_controller #(.INDEX_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] JUNK = 128'hA5A5_5A5A_DEAD_BEEF_0BAD_F00D_C3C3_3C3C;

  // Memory response timing for the next block read: busy stays low for
  // mem_pre cycles after mem_read is seen, then high for mem_high cycles,
  // then low for one cycle with the block on mem_readdata.
  int mem_pre  = 0;
  int mem_high = 4;

  // Cache contents as the CPU should observe them: per line valid + tag.
  bit          m_valid [8];
  logic [24:0] m_tag   [8];
  logic [27:0] exp_block = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] block_data(input logic [27:0] blk);
    return {blk, 2'd3, 2'b00, blk, 2'd2, 2'b00, blk, 2'd1, 2'b00, blk, 2'd0, 2'b00};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  // Instruction memory model: keeps running even if mem_read drops, so a
  // response can arrive after a reset has abandoned the request.
  bit          m_act  = 1'b0;
  bit          m_prev = 1'b0;
  int          m_t    = 0;
  logic [27:0] m_blk  = '0;
  always @(posedge clk) begin
    if (!m_act && bus.mem_read === 1'b1 && !m_prev) begin
      m_act = 1'b1;
      m_t   = 0;
      m_blk = bus.mem_address;
    end
    m_prev = (bus.mem_read === 1'b1);
    if (m_act) begin
      m_t++;
      bus.mem_busywait <= (m_t > mem_pre) && (m_t <= mem_pre + mem_high);
      if (m_t == mem_pre + mem_high + 1) begin
        bus.mem_readdata <= block_data(m_blk);
        m_act = 1'b0;
      end else begin
        bus.mem_readdata <= JUNK;
      end
    end else begin
      bus.mem_busywait <= 1'b0;
      bus.mem_readdata <= JUNK;
    end
  end

  // Every-cycle checks of the CPU-visible rules.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.read && !bus.busywait)
        check("hit_word", {96'd0, bus.instruction}, {96'd0, bus.pc[31:2], 2'b00});
      if (!bus.read) begin
        check("noread_busywait", {127'd0, bus.busywait}, 128'd0);
        check("noread_mem_read", {127'd0, bus.mem_read}, 128'd0);
      end
      if (bus.mem_read)
        check("mem_address", {100'd0, bus.mem_address}, {100'd0, exp_block});
    end
  end

  // One fetch from pc a; returns the busywait cycles and the first block
  // address requested. Called at posedge+1, returns at posedge+1.
  task automatic fetch(input logic [31:0] a, input int pre, input int high,
                       output int stall, output logic [27:0] first_addr);
    int   idx;
    bit   mhit;
    int   exp_stall;
    bit   seen;
    bit   done;
    idx       = int'(a[6:4]);
    mhit      = m_valid[idx] && (m_tag[idx] == a[31:7]);
    // detect cycle + (request cycle + pre + high + data cycle) + update cycle
    exp_stall = mhit ? 0 : 4 + pre + high;
    mem_pre   = pre;
    mem_high  = high;
    if (!mhit) exp_block = a[31:4];
    bus.pc    = a;
    bus.read  = 1'b1;
    stall      = 0;
    seen       = 1'b0;
    done       = 1'b0;
    first_addr = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.mem_read && !seen) begin
        seen       = 1'b1;
        first_addr = bus.mem_address;
      end
      if (!bus.busywait) begin
        done = 1'b1;
        break;
      end
      stall++;
    end
    if (!done) check("fetch_timeout", 128'd0, 128'd1);
    check("model_stall", stall, exp_stall);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a[31:7];
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          st;
  logic [27:0] fa;

  initial begin
    model_clear();
    reset    = 1'b1;
    bus.read = 1'b0;
    bus.pc   = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_instruction", {96'd0, bus.instruction}, 128'd0);
    check("rst_busywait",    {127'd0, bus.busywait}, 128'd0);
    check("rst_mem_read",    {127'd0, bus.mem_read}, 128'd0);
    check("rst_mem_address", {100'd0, bus.mem_address}, 128'd0);
    @(posedge clk); #1;

    // 1. Cold miss
    fetch(32'h14, 0, 4, st, fa);
    check("t1_stall", st, 8);
    check("t1_mem_address", {100'd0, fa}, 128'h1);

    // 2. Same-line hits on consecutive cycles
    fetch(32'h18, 0, 4, st, fa);
    check("t2_stall_18", st, 0);
    check("t2_mem_read_18", {127'd0, bus.mem_read}, 128'd0);
    fetch(32'h1C, 0, 4, st, fa);
    check("t2_stall_1c", st, 0);
    check("t2_mem_read_1c", {127'd0, bus.mem_read}, 128'd0);

    // 3. Conflict eviction on line 1 and refetch
    fetch(32'h94, 0, 4, st, fa);
    check("t3_stall_94", st, 8);
    check("t3_mem_address_94", {100'd0, fa}, 128'h9);
    fetch(32'h14, 0, 4, st, fa);
    check("t3_stall_14", st, 8);
    check("t3_mem_address_14", {100'd0, fa}, 128'h1);

    // 4. Memory slow to assert busy: must not fill on the early low cycles
    fetch(32'h200, 2, 3, st, fa);
    check("t4_stall", st, 9);
    check("t4_mem_address", {100'd0, fa}, 128'h20);

    // 5. Reset during MEM_READ
    exp_block = 28'h31;
    mem_pre   = 0;
    mem_high  = 4;
    bus.pc    = 32'h318;
    bus.read  = 1'b1;
    @(negedge clk);
    check("t5_miss_busywait", {127'd0, bus.busywait}, 128'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_mem_read", {127'd0, bus.mem_read}, 128'd1);
    @(posedge clk); #1;
    reset    = 1'b1;
    bus.read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("t5_post_mem_read", {127'd0, bus.mem_read}, 128'd0);
    check("t5_post_instruction", {96'd0, bus.instruction}, 128'd0);
    repeat (10) @(posedge clk);
    #1;
    fetch(32'h18, 0, 4, st, fa);
    check("t5_refetch_stall", st, 8);
    check("t5_refetch_addr", {100'd0, fa}, 128'h1);

    // 6. No request: nothing happens, controller stays idle
    bus.pc   = 32'h40;
    bus.read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_busywait", {127'd0, bus.busywait}, 128'd0);
      check("t6_mem_read", {127'd0, bus.mem_read}, 128'd0);
      @(posedge clk); #1;
    end
    fetch(32'h18, 0, 4, st, fa);
    check("t6_idle_hit", st, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
